memlcd_rx: RTL and testbench
============================

Name: memlcd_rx

Overview:
- Receive-side decoder for the Sharp memory-LCD serial bus driven on lcd_sclk, lcd_si and lcd_scs.
- Oversamples the three bus wires on refclk, reconstructs mode, line address and pixel bytes, and flags framing errors.
- Sits in the simulation benches next to the memlcd transmitter as a checking monitor, and is synthesizable for loopback self-test.

Parameters:
- MODE_BITS, 6, mode field width; bit 0 is M0 (update), bit 1 is M1 (VCOM), bit 2 is M2 (all-clear).
- ADDR_BITS, 10, gate/line address width.
- PIXELS, 336, pixels per line; must be a multiple of 8.
- DUMMY_BITS, 16, trailer bits after each line, or after the address for all-clear.

Ports:
- refclk  in  1  system clock; must be at least 4x the lcd_sclk rate.
- rst  in  1  synchronous, active-high reset.
- lcd_sclk  in  1  serial clock, asynchronous to refclk.
- lcd_si  in  1  serial data, valid on lcd_sclk rising edge.
- lcd_scs  in  1  chip select, active high.
- mode  out  MODE_BITS  mode field of the current line.
- line_addr  out  ADDR_BITS  address of the current line.
- pix_data  out  8  pixel byte; pixel 0 of the byte is in bit 0.
- pix_idx  out  $clog2(PIXELS/8)  byte index within the line.
- pix_valid  out  1  one-cycle strobe qualifying pix_data and pix_idx.
- line_valid  out  1  one-cycle strobe: line complete, including dummy bits.
- clear_all  out  1  one-cycle strobe: all-clear command complete.
- frame_done  out  1  one-cycle strobe: lcd_scs fell on a clean boundary.
- err_truncated  out  1  one-cycle strobe: lcd_scs fell mid-field.
- busy  out  1  high while the synchronized lcd_scs is high.

Behaviour:
- Reset: all outputs 0. State IDLE, counters 0, shift register 0.
- Reset is honoured in any state. A transfer in progress is discarded with no strobes. After reset the block waits for a fresh lcd_scs rising edge; a transfer already in progress at reset release is ignored until lcd_scs goes low.
- Input conditioning:
  - Each wire passes through a 2-flop synchronizer, then one history flop.
  - sclk_rise = synchronized lcd_sclk high AND history flop low.
  - si is sampled from the synchronized stage in the same cycle as sclk_rise.
  - Pin-edge to internal sample latency is 3 refclk cycles.
  - Strobe outputs are registered and assert 1 cycle after the causing sample, i.e. at most 4 refclk cycles after the pin edge.
- Bit order:
  - Mode field: M0 first.
  - Address field: LSB first.
  - Data: pixel 0 first.
  - Each field is shifted into its register LSB-first.
- States and transitions:
  - IDLE: on lcd_scs rise, go to MODE and clear bit_cnt.
  - MODE: after MODE_BITS samples, latch mode, go to ADDR.
  - ADDR: after ADDR_BITS samples, latch line_addr. If mode[2]=1, go to DUMMY with the no-data flag set; otherwise go to DATA.
  - DATA: after every 8th sample, pulse pix_valid with the assembled byte and pix_idx; pix_idx increments from 0 to PIXELS/8-1. After PIXELS samples, go to DUMMY.
  - DUMMY: discard DUMMY_BITS samples. On completion, pulse clear_all if the no-data flag is set, else pulse line_valid. Return to MODE with bit_cnt cleared; multi-line frames repeat the full header per line.
- lcd_scs fall:
  - In MODE with bit_cnt=0: pulse frame_done, go to IDLE.
  - In any other state, or in MODE with bit_cnt != 0: pulse err_truncated, go to IDLE, emit no line_valid.
  - lcd_scs fall in the same cycle as a completing sample: the sample completes first, including its strobe; the fall is processed the next cycle.
- sclk_rise while lcd_scs is low is ignored. lcd_scs rise while busy cannot occur.
- mode and line_addr hold their last latched value until they are overwritten.
- pix_data holds between strobes.
- No backpressure: at most one strobe per 8 sclk periods, so no overflow is possible.
- bit_cnt width is $clog2(max(PIXELS, DUMMY_BITS, ADDR_BITS, MODE_BITS)+1). It saturates nowhere because every state clears it on exit.

Decomposition:
- Package memlcd_pkg holds:
  - the mode bit index constants: M_UPDATE=0, M_VCOM=1, M_CLEAR=2;
  - the state enum: IDLE, MODE, ADDR, DATA, DUMMY.
- Sub-module memlcd_rx_sync: 2-flop synchronizers and edge detect. It outputs sclk_rise, si_s, scs_s, scs_rise and scs_fall.

Test Plan:
- Single-line write:
  - Stimulus: scs high; mode 6'b000001; addr 10'd5; 42 bytes of 0xA5; 16 dummy bits; scs low.
  - Response: 42 pix_valid with pix_data=0xA5 and pix_idx 0..41; line_valid with line_addr=5 and mode=1; then frame_done.
- Two lines in one frame:
  - Stimulus: addr 10'd0 with data 0x00, then addr 10'd535 with data 0xFF.
  - Response: two line_valid strobes with addr 0 then 535; one frame_done; 84 pix_valid in total.
- All-clear:
  - Stimulus: mode 6'b000100, addr 0, 16 dummy bits, scs low.
  - Response: clear_all once; zero pix_valid; zero line_valid; frame_done once.
- Truncation:
  - Stimulus: scs drops after 100 data bits of line addr 7.
  - Response: 12 pix_valid; err_truncated once; no line_valid; no frame_done; busy=0.
- Reset mid-line:
  - Stimulus: rst for 1 cycle after 50 data bits; the transmitter completes the line; then a clean frame with addr 9.
  - Response: no strobes for the aborted line; the following frame yields line_valid with addr 9.
- Rate margin:
  - Stimulus: sclk period = 4 refclk periods, VCOM mode 6'b000011, addr 1.
  - Response: all bytes decode correctly; mode=3 reported.

Source files
------------

// File: rtl/memlcd_pkg.sv
// Shared constants and state encoding for the memory-LCD receive decoder.
package memlcd_pkg;

    // Bit positions inside the mode field.
    localparam int M_UPDATE = 0;
    localparam int M_VCOM   = 1;
    localparam int M_CLEAR  = 2;

    typedef enum logic [2:0] {
        IDLE,
        MODE,
        ADDR,
        DATA,
        DUMMY
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/memlcd_rx_sync.sv
// Brings the three memory-LCD bus wires into the refclk domain and finds edges.
// The synchronizer flops carry no reset so that a chip select already high
// across a reset pulse does not look like a fresh rising edge afterwards.
module memlcd_rx_sync (
    input  logic clk,
    input  logic lcd_sclk,
    input  logic lcd_si,
    input  logic lcd_scs,
    output logic sclk_rise,
    output logic si_s,
    output logic scs_s,
    output logic scs_rise,
    output logic scs_fall
);

    // [0] metastable stage, [1] synchronized, [2] history
    logic [2:0] sclk_q, sclk_d;
    logic [2:0] scs_q,  scs_d;
    logic [1:0] si_q,   si_d;

    // Next values of the shift chains.
    always_comb begin
        sclk_d = {sclk_q[1:0], lcd_sclk};
        scs_d  = {scs_q[1:0],  lcd_scs};
        si_d   = {si_q[0],     lcd_si};
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk) begin
        sclk_q <= sclk_d;
        scs_q  <= scs_d;
        si_q   <= si_d;
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign si_s      = si_q[1];
    assign scs_s     = scs_q[1];
    assign scs_rise  = scs_q[1] & ~scs_q[2];
    assign scs_fall  = ~scs_q[1] & scs_q[2];

endmodule

// File: rtl/memlcd_rx.sv
// Memory-LCD serial bus monitor: rebuilds mode, line address and pixel bytes
// from oversampled sclk/si/scs and reports line, clear and framing events.
module memlcd_rx
    import memlcd_pkg::*;
#(
    parameter int MODE_BITS  = 6,
    parameter int ADDR_BITS  = 10,
    parameter int PIXELS     = 336,
    parameter int DUMMY_BITS = 16
) (
    input  logic                            refclk,
    input  logic                            rst,
    input  logic                            lcd_sclk,
    input  logic                            lcd_si,
    input  logic                            lcd_scs,
    output logic [MODE_BITS-1:0]            mode,
    output logic [ADDR_BITS-1:0]            line_addr,
    output logic [7:0]                      pix_data,
    output logic [$clog2(PIXELS/8)-1:0]     pix_idx,
    output logic                            pix_valid,
    output logic                            line_valid,
    output logic                            clear_all,
    output logic                            frame_done,
    output logic                            err_truncated,
    output logic                            busy
);

    localparam int IDX_W = $clog2(PIXELS/8);
    localparam int CNT_W = $clog2(max_of(max_of(PIXELS, DUMMY_BITS),
                                         max_of(ADDR_BITS, MODE_BITS)) + 1);
    // Wide enough for the longest field shifted in as a whole.
    localparam int SH_W  = max_of(max_of(MODE_BITS, ADDR_BITS), 8);

    logic sclk_rise, si_s, scs_s, scs_rise, scs_fall;

    memlcd_rx_sync u_sync (
        .clk       (refclk),
        .lcd_sclk  (lcd_sclk),
        .lcd_si    (lcd_si),
        .lcd_scs   (lcd_scs),
        .sclk_rise (sclk_rise),
        .si_s      (si_s),
        .scs_s     (scs_s),
        .scs_rise  (scs_rise),
        .scs_fall  (scs_fall)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SH_W-1:0]      shift_q, shift_d, shift_in;
    logic [MODE_BITS-1:0] mode_q, mode_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           pix_data_q, pix_data_d;
    logic [IDX_W-1:0]     pix_idx_q, pix_idx_d;
    logic                 nodata_q, nodata_d;
    logic                 fall_pend_q, fall_pend_d;
    logic                 armed_q, armed_d;
    logic                 busy_q, busy_d;
    logic                 pix_valid_q, pix_valid_d;
    logic                 line_valid_q, line_valid_d;
    logic                 clear_all_q, clear_all_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_q, err_d;

    // Decode FSM: one sample per sclk rise; a chip-select fall that coincides
    // with a sample is deferred one cycle so the sample's strobe lands first.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        pix_data_d   = pix_data_q;
        pix_idx_d    = pix_idx_q;
        nodata_d     = nodata_q;
        fall_pend_d  = 1'b0;
        // Only a chip select seen low since reset may start a transfer.
        armed_d      = armed_q | ~scs_s;
        busy_d       = scs_s;
        pix_valid_d  = 1'b0;
        line_valid_d = 1'b0;
        clear_all_d  = 1'b0;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        shift_in     = {si_s, shift_q[SH_W-1:1]};

        if (state_q == IDLE) begin
            if (scs_rise && armed_q) begin
                state_d = MODE;
                cnt_d   = '0;
            end
        end else if (sclk_rise && !fall_pend_q) begin
            shift_d     = shift_in;
            cnt_d       = cnt_q + CNT_W'(1);
            fall_pend_d = scs_fall;
            unique case (state_q)
                MODE: begin
                    if (cnt_q == CNT_W'(MODE_BITS - 1)) begin
                        mode_d  = shift_in[SH_W-1 -: MODE_BITS];
                        state_d = ADDR;
                        cnt_d   = '0;
                    end
                end
                ADDR: begin
                    if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                        addr_d   = shift_in[SH_W-1 -: ADDR_BITS];
                        nodata_d = mode_q[M_CLEAR];
                        state_d  = mode_q[M_CLEAR] ? DUMMY : DATA;
                        cnt_d    = '0;
                    end
                end
                DATA: begin
                    if (cnt_q[2:0] == 3'd7) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = shift_in[SH_W-1 -: 8];
                        pix_idx_d   = IDX_W'(cnt_q >> 3);
                    end
                    if (cnt_q == CNT_W'(PIXELS - 1)) begin
                        state_d = DUMMY;
                        cnt_d   = '0;
                    end
                end
                DUMMY: begin
                    if (cnt_q == CNT_W'(DUMMY_BITS - 1)) begin
                        clear_all_d  = nodata_q;
                        line_valid_d = ~nodata_q;
                        nodata_d     = 1'b0;
                        state_d      = MODE;
                        cnt_d        = '0;
                    end
                end
                default: ;
            endcase
        end else if (scs_fall || fall_pend_q) begin
            if (state_q == MODE && cnt_q == '0) frame_done_d = 1'b1;
            else                                err_d        = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            nodata_d = 1'b0;
        end
    end

    // State, datapath and strobe registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            mode_q       <= '0;
            addr_q       <= '0;
            pix_data_q   <= '0;
            pix_idx_q    <= '0;
            nodata_q     <= 1'b0;
            fall_pend_q  <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            pix_valid_q  <= 1'b0;
            line_valid_q <= 1'b0;
            clear_all_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            pix_data_q   <= pix_data_d;
            pix_idx_q    <= pix_idx_d;
            nodata_q     <= nodata_d;
            fall_pend_q  <= fall_pend_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
            pix_valid_q  <= pix_valid_d;
            line_valid_q <= line_valid_d;
            clear_all_q  <= clear_all_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign mode          = mode_q;
    assign line_addr     = addr_q;
    assign pix_data      = pix_data_q;
    assign pix_idx       = pix_idx_q;
    assign pix_valid     = pix_valid_q;
    assign line_valid    = line_valid_q;
    assign clear_all     = clear_all_q;
    assign frame_done    = frame_done_q;
    assign err_truncated = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_memlcd_rx.sv
// Randomized bench for memlcd_rx: drives whole frames on the serial pins and
// compares observed strobes with events derived from line/bit arithmetic.
module tb_memlcd_rx;
    import memlcd_pkg::*;

    localparam int MB = 6, AB = 10, PX = 336, DB = 16;
    localparam int NB = PX / 8;
    localparam int IW = $clog2(NB);

    logic          refclk = 1'b0;
    logic          rst = 1'b1, lcd_sclk = 1'b0, lcd_si = 1'b0, lcd_scs = 1'b0;
    logic [MB-1:0] mode;
    logic [AB-1:0] line_addr;
    logic [7:0]    pix_data;
    logic [IW-1:0] pix_idx;
    logic          pix_valid, line_valid, clear_all, frame_done, err_truncated, busy;

    always #5 refclk = ~refclk;

    memlcd_rx #(.MODE_BITS(MB), .ADDR_BITS(AB), .PIXELS(PX), .DUMMY_BITS(DB)) dut (
        .refclk(refclk), .rst(rst), .lcd_sclk(lcd_sclk), .lcd_si(lcd_si), .lcd_scs(lcd_scs),
        .mode(mode), .line_addr(line_addr), .pix_data(pix_data), .pix_idx(pix_idx),
        .pix_valid(pix_valid), .line_valid(line_valid), .clear_all(clear_all),
        .frame_done(frame_done), .err_truncated(err_truncated), .busy(busy)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed strobes, sampled away from the active edge.
    logic [31:0] got_pix[$], got_line[$];
    int got_clr = 0, got_fd = 0, got_err = 0;
    always @(negedge refclk) begin
        if (pix_valid)     got_pix.push_back((32'(pix_idx) << 8) | 32'(pix_data));
        if (line_valid)    got_line.push_back((32'(line_addr) << MB) | 32'(mode));
        if (clear_all)     got_clr++;
        if (frame_done)    got_fd++;
        if (err_truncated) got_err++;
    end

    // Frame under test: per-line mode/address and NB bytes per line.
    int       lm[$], la[$];
    bit [7:0] ld[$];
    bit       bits[$];
    int       per = 6;

    task automatic cyc(input int n);
        repeat (n) @(posedge refclk);
        #2;
    endtask

    task automatic new_frame();
        lm.delete(); la.delete(); ld.delete(); bits.delete();
        got_pix.delete(); got_line.delete();
        got_clr = 0; got_fd = 0; got_err = 0;
    endtask

    // fill < 0 means random bytes.
    task automatic add_line(input int m, input int a, input int fill);
        lm.push_back(m); la.push_back(a);
        for (int b = 0; b < NB; b++)
            ld.push_back(fill < 0 ? 8'($urandom) : 8'(fill));
    endtask

    // Serialize the frame: mode M0 first, address LSB first, pixel 0 first.
    task automatic build_bits();
        int m, a;
        for (int i = 0; i < lm.size(); i++) begin
            m = lm[i]; a = la[i];
            for (int k = 0; k < MB; k++) bits.push_back(m[k]);
            for (int k = 0; k < AB; k++) bits.push_back(a[k]);
            if (!m[M_CLEAR])
                for (int b = 0; b < NB; b++)
                    for (int k = 0; k < 8; k++) bits.push_back(ld[i*NB+b][k]);
            for (int k = 0; k < DB; k++) bits.push_back(1'b0);
        end
    endtask

    // Drive nbits of the frame (all if negative); pulse rst after rst_at bits.
    task automatic send(input int nbits, input int rst_at);
        int n;
        n = (nbits < 0) ? bits.size() : nbits;
        lcd_scs = 1'b1;
        cyc(3);
        for (int k = 0; k < n; k++) begin
            lcd_si = bits[k];
            cyc(per / 2);
            lcd_sclk = 1'b1;
            cyc(per - per / 2);
            lcd_sclk = 1'b0;
            if (k + 1 == rst_at) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
        end
        cyc(3);
        lcd_scs = 1'b0;
        cyc(10);
    endtask

    // Expected events for the first B bits of the frame, from field lengths.
    task automatic check_frame(input string tag, input int B, input bit aborted);
        logic [31:0] ep[$], el[$];
        int off, hdr, fin, ec, m;
        bit fd;
        off = 0; ec = 0;
        for (int i = 0; i < lm.size(); i++) begin
            m = lm[i];
            hdr = off + MB + AB;
            if (m[M_CLEAR]) begin
                fin = hdr + DB;
                if (fin <= B) ec++;
            end else begin
                for (int b = 0; b < NB; b++)
                    if (hdr + 8 * (b + 1) <= B) ep.push_back((b << 8) | int'(ld[i*NB+b]));
                fin = hdr + PX + DB;
                if (fin <= B) el.push_back((la[i] << MB) | m);
            end
            off = fin;
        end
        fd = !aborted && (B == bits.size());
        chk({tag, ".npix"}, got_pix.size(), ep.size());
        for (int i = 0; i < ep.size() && i < got_pix.size(); i++)
            chk({tag, ".pix"}, got_pix[i], ep[i]);
        chk({tag, ".nline"}, got_line.size(), el.size());
        for (int i = 0; i < el.size() && i < got_line.size(); i++)
            chk({tag, ".line"}, got_line[i], el[i]);
        chk({tag, ".clear"}, got_clr, ec);
        chk({tag, ".fdone"}, got_fd, fd ? 1 : 0);
        chk({tag, ".trunc"}, got_err, (!aborted && !fd) ? 1 : 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, bsent;
        cyc(5);
        chk("rst.pix_valid", pix_valid, 0);
        chk("rst.line_valid", line_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.mode", mode, 0);
        chk("rst.line_addr", line_addr, 0);
        chk("rst.pix_data", pix_data, 0);
        rst = 1'b0;
        cyc(4);

        // Single line of 0xA5.
        new_frame(); per = $urandom_range(4, 8);
        add_line(1 << M_UPDATE, 5, 'hA5); build_bits(); send(-1, -1);
        check_frame("single", bits.size(), 1'b0);
        chk("single.mode", mode, 1);

        // Two lines in one frame.
        new_frame(); per = $urandom_range(4, 8);
        add_line(1, 0, 'h00); add_line(1, 535, 'hFF); build_bits(); send(-1, -1);
        check_frame("two", bits.size(), 1'b0);

        // All-clear.
        new_frame();
        add_line(1 << M_CLEAR, 0, 0); build_bits(); send(-1, -1);
        check_frame("clear", bits.size(), 1'b0);

        // Truncation after 100 data bits.
        new_frame();
        add_line(1, 7, -1); build_bits(); send(MB + AB + 100, -1);
        check_frame("trunc", MB + AB + 100, 1'b0);

        // Reset after 50 data bits, transmitter finishes the line regardless.
        new_frame();
        add_line(1, 3, -1); build_bits(); send(-1, MB + AB + 50);
        check_frame("rstmid", MB + AB + 50, 1'b1);
        new_frame();
        add_line(1, 9, -1); build_bits(); send(-1, -1);
        check_frame("after_rst", bits.size(), 1'b0);

        // Minimum oversampling ratio, VCOM mode.
        new_frame(); per = 4;
        add_line((1 << M_UPDATE) | (1 << M_VCOM), 1, -1); build_bits(); send(-1, -1);
        check_frame("rate", bits.size(), 1'b0);
        chk("rate.mode", mode, 3);

        // Random frames; the last one is cut at a random bit.
        for (int f = 0; f < 3; f++) begin
            new_frame(); per = $urandom_range(4, 6);
            nl = $urandom_range(1, 2);
            for (int i = 0; i < nl; i++)
                add_line(int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)), -1);
            build_bits();
            bsent = (f == 2) ? int'($urandom_range(1, bits.size())) : bits.size();
            send(bsent, -1);
            check_frame("rand", bsent, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
